// File: rtl/clk_divide_pkg.sv
// Shared constants and encodings for the multi-channel clock divider.
//   DEF_WIDTH     : default counter/divisor width
//   DEF_RESET_DIV : default divisor loaded by reset (1 Hz from 50 MHz)
//   mode_e        : per-channel output mode (square wave or single pulse)
package clk_divide_pkg;

   localparam int unsigned DEF_WIDTH     = 26;
   localparam int unsigned DEF_RESET_DIV = 49_999_999;

   typedef enum logic {
      MODE_SQUARE = 1'b0,
      MODE_PULSE  = 1'b1
   } mode_e;

endpackage

// File: rtl/clk_divide_chan.sv
// One divider channel: counts 0..div_cur while enabled and raises a one-cycle
// tick at the terminal count. In square mode o toggles on each terminal, in
// pulse mode o mirrors the terminal strobe. Written divisors wait in div_pend
// and are applied only at a terminal edge (or at the next edge while disabled).
// Ports:
//   c, reset     : clock, synchronous active-high reset
//   en, mode     : run enable, output mode (0 square, 1 pulse)
//   wr, din      : divisor write strobe and value
//   o, tick      : registered divided output and terminal strobe
//   pending      : a written divisor is awaiting application
//   count        : live counter value
module clk_divide_chan
   import clk_divide_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned RESET_DIV = DEF_RESET_DIV
) (
   input  logic             c,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   output logic             o,
   output logic             tick,
   output logic             pending,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] div_cur;
   logic [WIDTH-1:0] div_pend;
   logic             pend;
   logic             term;
   mode_e            mode_q;

   assign mode_q  = mode_e'(mode);
   assign term    = (cnt == div_cur);
   assign pending = pend;
   assign count   = cnt;

   always_ff @(posedge c) begin
      if (reset) begin
         cnt      <= '0;
         div_cur  <= WIDTH'(RESET_DIV);
         div_pend <= WIDTH'(RESET_DIV);
         pend     <= 1'b0;
         o        <= 1'b0;
         tick     <= 1'b0;
      end else begin
         if (en) begin
            if (term) begin
               cnt  <= '0;
               tick <= 1'b1;
               o    <= (mode_q == MODE_PULSE) ? 1'b1 : ~o;
               if (pend) begin
                  div_cur <= div_pend;
                  pend    <= 1'b0;
               end
            end else begin
               cnt  <= cnt + WIDTH'(1);
               tick <= 1'b0;
               // square mode holds its level between terminals
               if (mode_q == MODE_PULSE)
                  o <= 1'b0;
            end
         end else begin
            // idle channel: output frozen, pending divisor taken immediately
            tick <= 1'b0;
            if (pend) begin
               div_cur <= div_pend;
               pend    <= 1'b0;
               cnt     <= '0;
            end
         end
         // a write on the applying edge reads the old div_pend above and
         // leaves the new value pending
         if (wr) begin
            div_pend <= din;
            pend     <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_divide_multi.sv
// Multi-channel clock-enable divider. Decodes the shared divisor write port
// into per-channel strobes and packs the channel counters. CHANNELS must be
// at least 2; writes with div_sel >= CHANNELS match no channel and are dropped.
// Ports:
//   c, reset        : clock, synchronous active-high reset
//   en, mode        : per-channel enable and mode (0 square, 1 pulse)
//   div_wr, div_sel : divisor write strobe and target channel
//   div_in          : divisor value
//   o, tick         : per-channel divided output and terminal strobe
//   pending         : per-channel divisor-waiting flag
//   count           : packed counters, channel k at [k*WIDTH +: WIDTH]
module clk_divide_multi
   import clk_divide_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned RESET_DIV = DEF_RESET_DIV
) (
   input  logic                        c,
   input  logic                        reset,
   input  logic [CHANNELS-1:0]         en,
   input  logic [CHANNELS-1:0]         mode,
   input  logic                        div_wr,
   input  logic [$clog2(CHANNELS)-1:0] div_sel,
   input  logic [WIDTH-1:0]            div_in,
   output logic [CHANNELS-1:0]         o,
   output logic [CHANNELS-1:0]         tick,
   output logic [CHANNELS-1:0]         pending,
   output logic [CHANNELS*WIDTH-1:0]   count
);

   localparam int unsigned SELW = $clog2(CHANNELS);

   logic [CHANNELS-1:0] wr;

   always_comb begin
      wr = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (div_wr && (div_sel == SELW'(k)))
            wr[k] = 1'b1;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      clk_divide_chan #(
         .WIDTH     (WIDTH),
         .RESET_DIV (RESET_DIV)
      ) u_chan (
         .c       (c),
         .reset   (reset),
         .en      (en[k]),
         .mode    (mode[k]),
         .wr      (wr[k]),
         .din     (div_in),
         .o       (o[k]),
         .tick    (tick[k]),
         .pending (pending[k]),
         .count   (count[k*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_clk_divide_multi.sv
// Directed bench for clk_divide_multi with WIDTH=8, CHANNELS=3, RESET_DIV=3.
module tb_clk_divide_multi;

   logic        c;
   logic        reset;
   logic [2:0]  en;
   logic [2:0]  mode;
   logic        div_wr;
   logic [1:0]  div_sel;
   logic [7:0]  div_in;
   logic [2:0]  o;
   logic [2:0]  tick;
   logic [2:0]  pending;
   logic [23:0] count;

   int vectors;
   int miscompares;

   clk_divide_multi #(
      .WIDTH     (8),
      .CHANNELS  (3),
      .RESET_DIV (3)
   ) dut (
      .c       (c),
      .reset   (reset),
      .en      (en),
      .mode    (mode),
      .div_wr  (div_wr),
      .div_sel (div_sel),
      .div_in  (div_in),
      .o       (o),
      .tick    (tick),
      .pending (pending),
      .count   (count)
   );

   initial begin
      c = 1'b0;
      forever #5 c = ~c;
   end

   task automatic step();
      @(posedge c);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      en     = 3'b000;
      mode   = 3'b000;
      div_wr = 1'b0;
      step();
      reset  = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset   = 1'b1;
      en      = 3'b000;
      mode    = 3'b000;
      div_wr  = 1'b0;
      div_sel = 2'd0;
      div_in  = 8'd0;
      step();
      step();

      // reset state
      chk("rst_o",     32'(o),       0);
      chk("rst_tick",  32'(tick),    0);
      chk("rst_pend",  32'(pending), 0);
      chk("rst_count", 32'(count),   0);

      // reset divisor 3, square: tick at 4,8,12; o rises at 4, falls at 8
      reset = 1'b0;
      en    = 3'b001;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("sq_tick0", 32'(tick[0]),     32'(i % 4 == 0));
         chk("sq_o0",    32'(o[0]),        32'((i / 4) % 2));
         chk("sq_cnt0",  32'(count[7:0]),  32'(i % 4));
      end

      // ch1 pulse mode, D=3: o equals tick, period 4
      mode = 3'b010;
      en   = 3'b011;
      for (int j = 1; j <= 8; j++) begin
         step();
         chk("pl_tick1", 32'(tick[1]), 32'(j % 4 == 0));
         chk("pl_o1",    32'(o[1]),    32'(j % 4 == 0));
      end
      // write D=0 to ch1: applied at edge 12, then o held high
      div_wr  = 1'b1;
      div_sel = 2'd1;
      div_in  = 8'd0;
      for (int j = 9; j <= 16; j++) begin
         step();
         div_wr = 1'b0;
         chk("d0_pend1", 32'(pending[1]), 32'(j < 12));
         chk("d0_o1",    32'(o[1]),       32'(j >= 12));
         chk("d0_tick1", 32'(tick[1]),    32'(j >= 12));
      end

      // glitch-free change: D=9 written at cnt=1, old period ends at edge 4,
      // next terminal at edge 14
      do_reset();
      en      = 3'b001;
      div_sel = 2'd0;
      div_in  = 8'd9;
      for (int k = 1; k <= 14; k++) begin
         div_wr = (k == 2);
         step();
         chk("gf_pend0", 32'(pending[0]),  32'(k >= 2 && k < 4));
         chk("gf_tick0", 32'(tick[0]),     32'(k == 4 || k == 14));
         chk("gf_cnt0",  32'(count[7:0]),  (k <= 4) ? 32'(k % 4) : ((k == 14) ? 32'd0 : 32'(k - 4)));
         chk("gf_o0",    32'(o[0]),        32'(k >= 4 && k < 14));
      end
      div_wr = 1'b0;

      // write on terminal edge: D=7 pending, D=5 written at edge 4
      do_reset();
      en      = 3'b001;
      div_sel = 2'd0;
      for (int k = 1; k <= 18; k++) begin
         div_wr = (k == 2 || k == 4);
         div_in = (k == 2) ? 8'd7 : 8'd5;
         step();
         chk("wt_pend0", 32'(pending[0]), 32'(k >= 2 && k < 12));
         chk("wt_tick0", 32'(tick[0]),    32'(k == 4 || k == 12 || k == 18));
         chk("wt_cnt0",  32'(count[7:0]),
             (k <= 4) ? 32'(k % 4) : ((k <= 12) ? 32'((k - 4) % 8) : 32'((k - 12) % 6)));
      end
      div_wr = 1'b0;

      // disable while pending: D=6 written at edge 5, en low for edges 7-8
      do_reset();
      div_sel = 2'd0;
      div_in  = 8'd6;
      for (int k = 1; k <= 15; k++) begin
         en     = (k == 7 || k == 8) ? 3'b000 : 3'b001;
         div_wr = (k == 5);
         step();
         chk("ds_pend0", 32'(pending[0]), 32'(k == 5 || k == 6));
         chk("ds_tick0", 32'(tick[0]),    32'(k == 4 || k == 15));
         chk("ds_o0",    32'(o[0]),       32'(k >= 4 && k < 15));
         chk("ds_cnt0",  32'(count[7:0]),
             (k <= 4) ? 32'(k % 4) : ((k <= 6) ? 32'(k - 4) : ((k <= 8 || k == 15) ? 32'd0 : 32'(k - 8))));
      end
      div_wr = 1'b0;

      // mid-run reset with ch1 at cnt=5 and a write pending
      do_reset();
      div_sel = 2'd1;
      div_in  = 8'd9;
      div_wr  = 1'b1;
      step();
      chk("mr_pend_a", 32'(pending[1]), 1);
      div_wr = 1'b0;
      step();
      chk("mr_pend_b", 32'(pending[1]),    0);
      chk("mr_cnt_b",  32'(count[15:8]),   0);
      en     = 3'b010;
      div_in = 8'd2;
      for (int k = 3; k <= 7; k++) begin
         div_wr = (k == 7);
         step();
      end
      div_wr = 1'b0;
      chk("mr_cnt5",  32'(count[15:8]), 5);
      chk("mr_pend5", 32'(pending[1]),  1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mr_count", 32'(count),   0);
      chk("mr_o",     32'(o),       0);
      chk("mr_pend",  32'(pending), 0);
      chk("mr_tick",  32'(tick),    0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("mr_tick1", 32'(tick[1]),     32'(k == 4));
         chk("mr_cnt1",  32'(count[15:8]), 32'(k % 4));
      end

      // out-of-range div_sel=3 is ignored
      do_reset();
      div_sel = 2'd3;
      div_in  = 8'd0;
      div_wr  = 1'b1;
      step();
      div_wr = 1'b0;
      chk("oor_pend", 32'(pending), 0);
      en = 3'b111;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("oor_tick", 32'(tick), (k == 4) ? 32'd7 : 32'd0);
      end
      chk("oor_count", 32'(count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clk_divide_multi.md
# clk_divide_multi

Parametrised, multi-channel successor to the single-output clock divider. Each channel derives a square-wave or single-pulse enable from the system clock using a run-time programmable divisor, with glitch-free ratio changes at the channel's terminal count. It feeds LED blinkers, display scan strobes and slow state machines throughout the lab designs. All outputs are synchronous enables in the `c` domain; no derived clocks are generated.

## Interface
- `WIDTH`, 26: counter and divisor width per channel.
- `CHANNELS`, 2: number of independent channels; must be ≥ 2.
- `RESET_DIV`, 49_999_999: divisor loaded by reset. Must fit in `WIDTH` bits.
- `c`  in  1  system clock. Only clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  CHANNELS  per-channel run enable.
- `mode`  in  CHANNELS  per-channel output mode: 0 = square, 1 = pulse.
- `div_wr`  in  1  divisor write strobe, one cycle.
- `div_sel`  in  $clog2(CHANNELS)  target channel for `div_wr`.
- `div_in`  in  WIDTH  divisor value D for `div_wr`.
- `o`  out  CHANNELS  divided output per channel, registered.
- `tick`  out  CHANNELS  one-cycle terminal strobe per channel, registered.
- `pending`  out  CHANNELS  a written divisor is waiting for the next terminal count.
- `count`  out  CHANNELS*WIDTH  live counter; channel k occupies bits [k*WIDTH +: WIDTH].

## Operation
- **Per-channel state:** `cnt`, `div_cur`, `div_pend`, `pend`.
- **Reset:** `cnt`=0, `div_cur`=`div_pend`=RESET_DIV, `pend`=0, `o`=0, `tick`=0.
- **Counting:** while `en`=1, `cnt` counts 0..`div_cur`. At `cnt`==`div_cur`, the terminal edge sets `cnt`←0 and `tick`←1; on all other edges `tick`←0.
- **Square mode:** `o` toggles on every terminal edge. Output period is 2·(D+1) cycles at 50% duty.
- **Pulse mode:** `o`←terminal, so it equals `tick`. Output period is D+1 cycles.
- **Mode changes:** `mode` is sampled every edge; changes apply from the next edge. Switching to square keeps the current `o` level.
- **D = 0:** terminal occurs every cycle. Square mode gives `o` = c/2; pulse mode holds `o` at 1.
- **Divisor write:** `div_wr` loads `div_in` into `div_pend[div_sel]` and sets `pend`. A second write before application overwrites the first (last write wins).
- **Divisor application:** on the next terminal edge, `div_cur`←`div_pend` and `pend`←0. The current period always completes with the old divisor, so no runt periods occur.
- **Write on a terminal edge:** the terminal edge applies any older pending value. The new write lands in `div_pend` and `pend` stays 1.
- **Disabled channel (`en`=0):**
  - `cnt` and `o` hold; `tick`=0.
  - A pending divisor is applied on the next edge and `cnt` is cleared to 0.
- **Out-of-range `div_sel`** (≥ CHANNELS): the write is ignored.
- **Reset mid-period:** immediately restores reset values; pending writes are discarded.

## Timing
- From the first enabled edge, the first `tick` is asserted D+1 edges later. It lasts exactly one cycle, then repeats every D+1 cycles.
- `o` and `tick` change on the same edge. There is no combinational path from inputs to outputs.
- `pending` rises the cycle after the `div_wr` edge. It falls in the cycle in which `count` shows 0 after application.
- `count` is the registered `cnt`, so zero-latency observation is possible.
- Channels are fully independent; simultaneous terminals on all channels are legal.

## Structure
- **Package `clk_divide_pkg`:** default constants (`DEF_WIDTH`=26, `DEF_RESET_DIV`) and mode encodings `MODE_SQUARE`=0, `MODE_PULSE`=1.
- **Sub-module `clk_divide_chan`:** one channel (`cnt`, `div_cur`, `div_pend`, `pend`, `o`, `tick`), instantiated CHANNELS times in a generate loop.
- **Top level:** only decodes `div_wr`/`div_sel` into per-channel write strobes and packs `count`.

## Test plan
- **Reset defaults:** WIDTH=8, RESET_DIV=3, ch0 square, `en`=1 from reset release → `tick` at edges 4, 8, 12; `o` rises at 4, falls at 8 (period 8).
- **Pulse mode:** ch1 pulse with D=3 → `o`==`tick` with period 4. Write D=0 → after the next terminal, `o` is held at 1.
- **Glitch-free ratio change:** write D=9 to ch0 at `cnt`=1 → current period still ends at `cnt`=3; the next terminal is 10 cycles later; `pending` spans the gap.
- **Write on terminal edge:** write D=5 exactly on ch0's terminal edge while D=7 is pending → D=7 is applied, `pending` stays 1, D=5 is applied at the following terminal.
- **Disable while pending:** `en`=0 at `cnt`=2 with a write pending → next edge `cnt`=0, new divisor active, `o` held, `tick`=0; re-enable → first `tick` D+1 edges later.
- **Mid-run reset:** assert `reset` while ch1 is at `cnt`=5 with a write pending → next edge all `cnt`=0, `o`=0, `pending`=0, divisor = RESET_DIV. Also check that `div_sel`=3 with CHANNELS=3 is ignored.
